mem_arbiter: RTL

Shares the single unified main memory between the instruction-fetch cache-miss path and the data cache-miss/write-through path of the 5-stage pipeline.
- Grants one requester at a time.
- Block fills: issues one address per cycle, then collects returning words and hands each to the granted cache.
- Data writes: performs a single-cycle write-through.
- Sits between the IF/MEM stage caches and the memory model.

---
 rtl/mem_arb_pkg.sv | 18 +
 rtl/mem_arbiter_fill_counter.sv | 43 ++++
 rtl/mem_arbiter.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and sizing helpers for the memory arbiter and its fill counter.
package mem_arb_pkg;

   localparam int unsigned BLOCK_WORDS_DEF = 8;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_WRITE  = 2'd1,
      ST_FILL_I = 2'd2,
      ST_FILL_D = 2'd3
   } arb_state_t;

   // Bits needed to index a word inside a block.
   function automatic int unsigned idx_w(input int unsigned words);
      return $clog2(words);
   endfunction

endpackage

// File: rtl/mem_arbiter_fill_counter.sv
// Issue and return word counters for block fills, with terminal flags.
module fill_counter
   import mem_arb_pkg::*;
#(
   parameter int unsigned BLOCK_WORDS = BLOCK_WORDS_DEF
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          i_clr,
   input  logic                          i_issue,
   input  logic                          i_ret,
   output logic [idx_w(BLOCK_WORDS)-1:0] o_issue_idx,
   output logic [idx_w(BLOCK_WORDS)-1:0] o_ret_idx,
   output logic                          o_issue_done,
   output logic                          o_ret_last
);

   localparam int unsigned IDX_W = idx_w(BLOCK_WORDS);
   // One extra bit so the issue count can reach BLOCK_WORDS without wrapping.
   localparam int unsigned CNT_W = IDX_W + 1;

   logic [CNT_W-1:0] r_issue_cnt;
   logic [CNT_W-1:0] r_ret_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_issue_cnt <= '0;
         r_ret_cnt   <= '0;
      end else if (i_clr) begin
         r_issue_cnt <= '0;
         r_ret_cnt   <= '0;
      end else begin
         if (i_issue) r_issue_cnt <= r_issue_cnt + CNT_W'(1);
         if (i_ret)   r_ret_cnt   <= r_ret_cnt + CNT_W'(1);
      end
   end

   assign o_issue_idx  = r_issue_cnt[IDX_W-1:0];
   assign o_ret_idx    = r_ret_cnt[IDX_W-1:0];
   assign o_issue_done = (r_issue_cnt == CNT_W'(BLOCK_WORDS));
   assign o_ret_last   = (r_ret_cnt == CNT_W'(BLOCK_WORDS - 1));

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the unified memory between I-side fills and D-side fills/write-through.
// Optional MEM_ARB_RR_EN: alternate priority on simultaneous requests.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int unsigned ADDR_W      = 16,
   parameter int unsigned DATA_W      = 16,
   parameter int unsigned BLOCK_WORDS = BLOCK_WORDS_DEF
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          i_req,
   input  logic [ADDR_W-1:0]             i_addr,
   input  logic                          d_req,
   input  logic                          d_we,
   input  logic [ADDR_W-1:0]             d_addr,
   input  logic [DATA_W-1:0]             d_wdata,
   output logic                          i_fill_valid,
   output logic                          d_fill_valid,
   output logic [idx_w(BLOCK_WORDS)-1:0] fill_idx,
   output logic [DATA_W-1:0]             fill_data,
   output logic                          i_done,
   output logic                          d_done,
   output logic                          busy,
   output logic                          mem_en,
   output logic                          mem_wr,
   output logic [ADDR_W-1:0]             mem_addr,
   output logic [DATA_W-1:0]             mem_wdata,
   input  logic                          mem_data_valid,
   input  logic [DATA_W-1:0]             mem_rdata
);

   localparam int unsigned IDX_W = idx_w(BLOCK_WORDS);

   arb_state_t        r_state;
   arb_state_t        w_next_state;
   logic [ADDR_W-1:1] r_addr;
   logic [DATA_W-1:0] r_wdata;

   logic              w_pick_d;
   logic              w_grant;
   logic [ADDR_W-1:0] w_grant_addr;
   logic              w_filling;
   logic              w_issue;
   logic              w_ret;
   logic              w_clr;
   logic [IDX_W-1:0]  w_issue_idx;
   logic [IDX_W-1:0]  w_ret_idx;
   logic              w_issue_done;
   logic              w_ret_last;
   logic              w_unused;

`ifdef MEM_ARB_RR_EN
   // 1 = D side wins the next tie; flips toward the side not granted last.
   logic r_prio_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)          r_prio_d <= 1'b1;
      else if (w_grant) r_prio_d <= ~w_pick_d;
   end

   assign w_pick_d = d_req & (~i_req | r_prio_d);
`else
   assign w_pick_d = d_req;
`endif

   assign w_grant      = (r_state == ST_IDLE) & (i_req | d_req);
   assign w_grant_addr = w_pick_d ? d_addr : i_addr;
   assign w_filling    = (r_state == ST_FILL_I) | (r_state == ST_FILL_D);
   assign w_issue      = w_filling & ~w_issue_done;
   assign w_ret        = w_filling & mem_data_valid;
   assign w_clr        = (w_next_state == ST_IDLE);
   // Byte-offset bit is never used: writes and fills are word aligned.
   assign w_unused     = w_grant_addr[0];

   fill_counter #(
      .BLOCK_WORDS (BLOCK_WORDS)
   ) u_fill_counter (
      .clk          (clk),
      .rst          (rst),
      .i_clr        (w_clr),
      .i_issue      (w_issue),
      .i_ret        (w_ret),
      .o_issue_idx  (w_issue_idx),
      .o_ret_idx    (w_ret_idx),
      .o_issue_done (w_issue_done),
      .o_ret_last   (w_ret_last)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_next_state;
   end

   // Request address and write data are captured only at the grant edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_addr  <= '0;
         r_wdata <= '0;
      end else if (w_grant) begin
         r_addr  <= w_grant_addr[ADDR_W-1:1];
         r_wdata <= d_wdata;
      end
   end

   always_comb begin
      w_next_state = r_state;
      busy         = (r_state != ST_IDLE);
      mem_en       = 1'b0;
      mem_wr       = 1'b0;
      mem_addr     = '0;
      mem_wdata    = '0;
      i_fill_valid = 1'b0;
      d_fill_valid = 1'b0;
      fill_idx     = '0;
      fill_data    = '0;
      i_done       = 1'b0;
      d_done       = 1'b0;

      case (r_state)
         ST_IDLE: begin
            if (w_pick_d)   w_next_state = d_we ? ST_WRITE : ST_FILL_D;
            else if (i_req) w_next_state = ST_FILL_I;
         end

         ST_WRITE: begin
            mem_en       = 1'b1;
            mem_wr       = 1'b1;
            mem_addr     = {r_addr, 1'b0};
            mem_wdata    = r_wdata;
            d_done       = 1'b1;
            w_next_state = ST_IDLE;
         end

         ST_FILL_I, ST_FILL_D: begin
            if (!w_issue_done) begin
               mem_en   = 1'b1;
               mem_addr = {r_addr[ADDR_W-1:IDX_W+1], w_issue_idx, 1'b0};
            end
            // Returns may overlap issues; each valid word goes to the owner.
            if (mem_data_valid) begin
               fill_idx  = w_ret_idx;
               fill_data = mem_rdata;
               if (r_state == ST_FILL_I) i_fill_valid = 1'b1;
               else                      d_fill_valid = 1'b1;
               if (w_ret_last) begin
                  if (r_state == ST_FILL_I) i_done = 1'b1;
                  else                      d_done = 1'b1;
                  w_next_state = ST_IDLE;
               end
            end
         end

         default: w_next_state = ST_IDLE;
      endcase
   end

endmodule
